// File: rtl/barrel_rotl_pipe.sv
// Two-stage pipelined 16-bit rotate-left (fine 0..3 bits, then coarse 0/4/8/12 bits) with valid/ready.
// Optional macro ROTL_SHIFT_MODE_EN adds in_mode: 1 = logical shift-left with zero fill.
module barrel_rotl_pipe (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_data,
   input  logic [3:0]  in_amt,
`ifdef ROTL_SHIFT_MODE_EN
   input  logic        in_mode,
`endif
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_data
);

   logic        s1_valid_reg;
   logic [15:0] s1_data_reg;
   logic [1:0]  s1_amt_hi_reg;
   logic        out_valid_reg;
   logic [15:0] out_data_reg;

   logic        s1_load;
   logic        s2_load;
   logic [15:0] fine_fill;
   logic [15:0] coarse_fill;
   logic [15:0] fine_opt   [4];
   logic [15:0] coarse_opt [4];
   logic [15:0] fine_word;
   logic [15:0] coarse_word;

   // The fill word supplies the bits shifted in from the right: the word itself
   // for a rotate, zeros for a logical shift.
`ifdef ROTL_SHIFT_MODE_EN
   logic s1_mode_reg;

   assign fine_fill   = in_mode ? 16'h0000 : in_data;
   assign coarse_fill = s1_mode_reg ? 16'h0000 : s1_data_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_mode_reg <= 1'b0;
      end else if (s1_load) begin
         s1_mode_reg <= in_mode;
      end
   end
`else
   assign fine_fill   = in_data;
   assign coarse_fill = s1_data_reg;
`endif

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_opt
         assign fine_opt[gi]   = (in_data << gi) | (fine_fill >> (16 - gi));
         assign coarse_opt[gi] = (s1_data_reg << (4 * gi)) | (coarse_fill >> (16 - 4 * gi));
      end
   endgenerate

   assign fine_word   = fine_opt[in_amt[1:0]];
   assign coarse_word = coarse_opt[s1_amt_hi_reg];

   // Back-pressure is a purely combinational chain from out_ready; no skid buffer.
   assign s2_load  = s1_valid_reg && (!out_valid_reg || out_ready);
   assign in_ready = !rst && (!s1_valid_reg || !out_valid_reg || out_ready);
   assign s1_load  = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_reg  <= 1'b0;
         s1_data_reg   <= 16'h0000;
         s1_amt_hi_reg <= 2'b00;
      end else if (s1_load) begin
         s1_valid_reg  <= 1'b1;
         s1_data_reg   <= fine_word;
         s1_amt_hi_reg <= in_amt[3:2];
      end else if (s2_load) begin
         s1_valid_reg  <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_reg <= 1'b0;
         out_data_reg  <= 16'h0000;
      end else if (s2_load) begin
         out_valid_reg <= 1'b1;
         out_data_reg  <= coarse_word;
      end else if (out_valid_reg && out_ready) begin
         out_valid_reg <= 1'b0;
      end
   end

   assign out_valid = out_valid_reg;
   assign out_data  = out_data_reg;

endmodule

// File: tb/tb_barrel_rotl_pipe.sv
// Bench for barrel_rotl_pipe: handshake-level scoreboard against an index-based rotate/shift model.
// Shift-mode checks are compiled only when ROTL_SHIFT_MODE_EN is defined.
module tb_barrel_rotl_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic [3:0]  in_amt;
   logic        in_mode;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;

   int total = 0;
   int bad   = 0;
   int cyc_cnt = 0;

   typedef struct packed {
      logic [15:0] d;
      logic [3:0]  a;
      logic        m;
   } txn_t;

   txn_t        acc_q [$];
   logic [15:0] got_q [$];

   always #5 clk = ~clk;

   barrel_rotl_pipe dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_amt    (in_amt),
`ifdef ROTL_SHIFT_MODE_EN
      .in_mode   (in_mode),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   // Y[i] = D[(i - amt) mod 16]; in shift mode bits below amt are zero.
   function automatic logic [15:0] model_out(txn_t t);
      logic [15:0] y;
      int sh;
      sh = int'(t.a);
      for (int i = 0; i < 16; i++) begin
         if (t.m && i < sh) y[i] = 1'b0;
         else               y[i] = t.d[(i - sh + 16) % 16];
      end
      return y;
   endfunction

   // Right rotator of the datapath: S[i] = A[(i + s) mod 16].
   function automatic logic [15:0] rotr16(logic [15:0] w, int a);
      logic [15:0] s;
      for (int i = 0; i < 16; i++) s[i] = w[(i + a) % 16];
      return s;
   endfunction

   // Observe handshakes mid-cycle, then advance to just after the next edge.
   task automatic tick();
      @(negedge clk);
      if (in_valid && in_ready) acc_q.push_back({in_data, in_amt, in_mode});
      if (out_valid && out_ready && !rst) got_q.push_back(out_data);
      @(posedge clk);
      #1;
      cyc_cnt++;
   endtask

   task automatic send(logic [15:0] d, logic [3:0] a, logic m);
      int n0;
      n0 = acc_q.size();
      in_valid = 1'b1;
      in_data  = d;
      in_amt   = a;
      in_mode  = m;
      for (int k = 0; k < 20 && acc_q.size() == n0; k++) tick();
      in_valid = 1'b0;
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 40 && got_q.size() < acc_q.size(); k++) tick();
      tick();
      tick();
   endtask

   task automatic clear_q();
      acc_q.delete();
      got_q.delete();
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      in_data = 16'h0000; in_amt = 4'd0; in_mode = 1'b0;
      tick();
      tick();
      total++; if (in_ready !== 1'b0)       begin bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
      total++; if (out_valid !== 1'b0)      begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      total++; if (out_data !== 16'h0000)   begin bad++; $display("FAIL reset_out_data: got %h want 0000", out_data); end
      rst = 1'b0;
      #1;
      total++; if (in_ready !== 1'b1)       begin bad++; $display("FAIL release_in_ready: got %b want 1", in_ready); end

      // Reset in the middle of traffic must discard the in-flight words.
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1; in_data = 16'($urandom); in_amt = 4'($urandom);
         tick();
      end
      rst = 1'b1;
      tick();
      total++; if (in_ready !== 1'b0)       begin bad++; $display("FAIL midrst_in_ready: got %b want 0", in_ready); end
      total++; if (out_valid !== 1'b0)      begin bad++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
      total++; if (out_data !== 16'h0000)   begin bad++; $display("FAIL midrst_out_data: got %h want 0000", out_data); end
      tick();
      rst = 1'b0; in_valid = 1'b0;
      #1;
      total++; if (in_ready !== 1'b1)       begin bad++; $display("FAIL midrst_release: got %b want 1", in_ready); end
      clear_q();
      for (int k = 0; k < 4; k++) tick();
      total++; if (got_q.size() != 0)       begin bad++; $display("FAIL midrst_ghost: got %0d words want 0", got_q.size()); end
   endtask

   task automatic test_latency();
      clear_q();
      out_ready = 1'b1;
      in_valid = 1'b1; in_data = 16'h0001; in_amt = 4'd5; in_mode = 1'b0;
      tick();
      in_valid = 1'b0;
      total++; if (out_valid !== 1'b0)      begin bad++; $display("FAIL lat_early: got out_valid %b want 0", out_valid); end
      tick();
      total++; if (out_valid !== 1'b1)      begin bad++; $display("FAIL lat_valid: got %b want 1", out_valid); end
      total++; if (out_data !== 16'h0020)   begin bad++; $display("FAIL lat_data: got %h want 0020", out_data); end
      in_valid = 1'b1; in_data = 16'h8001; in_amt = 4'd1;
      tick();
      in_valid = 1'b0;
      tick();
      total++; if (out_valid !== 1'b1 || out_data !== 16'h0003)
         begin bad++; $display("FAIL lat_second: got v=%b %h want v=1 0003", out_valid, out_data); end
      drain();
   endtask

   task automatic test_boundary();
      logic [15:0] d_tab [5];
      logic [3:0]  a_tab [5];
      logic [15:0] e_tab [5];
      d_tab = '{16'hA5A5, 16'h0001, 16'h4123, 16'h8001, 16'h0001};
      a_tab = '{4'd0,     4'd15,    4'd4,     4'd1,     4'd5};
      e_tab = '{16'hA5A5, 16'h8000, 16'h1234, 16'h0003, 16'h0020};
      clear_q();
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) send(d_tab[i], a_tab[i], 1'b0);
      drain();
      total++; if (got_q.size() != 5)       begin bad++; $display("FAIL bound_count: got %0d want 5", got_q.size()); end
      for (int i = 0; i < 5 && i < got_q.size(); i++) begin
         total++;
         if (got_q[i] !== e_tab[i]) begin bad++; $display("FAIL bound_%0d: got %h want %h", i, got_q[i], e_tab[i]); end
      end
   endtask

   task automatic test_inverse();
      logic [15:0] orig_q [$];
      logic [15:0] w;
      int c0;
      clear_q();
      out_ready = 1'b1;
      c0 = cyc_cnt;
      for (int a = 0; a < 16; a++) begin
         for (int j = 0; j < 64; j++) begin
            w = 16'($urandom);
            orig_q.push_back(w);
            send(rotr16(w, a), 4'(a), 1'b0);
         end
      end
      total++; if (cyc_cnt - c0 != 1024)    begin bad++; $display("FAIL inv_throughput: got %0d cycles want 1024", cyc_cnt - c0); end
      drain();
      total++; if (got_q.size() != 1024)    begin bad++; $display("FAIL inv_count: got %0d want 1024", got_q.size()); end
      for (int i = 0; i < 1024 && i < got_q.size(); i++) begin
         total++;
         if (got_q[i] !== orig_q[i]) begin bad++; $display("FAIL inv_%0d: got %h want %h", i, got_q[i], orig_q[i]); end
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] w [8];
      logic [3:0]  a [8];
      logic [15:0] held;
      held = 16'h0000;
      for (int i = 0; i < 8; i++) begin w[i] = 16'($urandom); a[i] = 4'($urandom); end
      clear_q();
      in_mode = 1'b0;
      for (int c = 0; c < 60 && got_q.size() < 8; c++) begin
         if (acc_q.size() < 8) begin
            in_valid = 1'b1; in_data = w[acc_q.size()]; in_amt = a[acc_q.size()];
         end else begin
            in_valid = 1'b0;
         end
         out_ready = !(c >= 3 && c < 8);
         #1;
         if (c >= 3 && c < 8) begin
            total++; if (in_ready !== 1'b0)  begin bad++; $display("FAIL stall_in_ready c%0d: got %b want 0", c, in_ready); end
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stall_out_valid c%0d: got %b want 1", c, out_valid); end
            if (c == 3) held = out_data;
            else begin
               total++; if (out_data !== held) begin bad++; $display("FAIL stall_hold c%0d: got %h want %h", c, out_data, held); end
            end
         end
         tick();
      end
      drain();
      total++; if (got_q.size() != 8)       begin bad++; $display("FAIL b2b_count: got %0d want 8", got_q.size()); end
      for (int i = 0; i < 8 && i < got_q.size(); i++) begin
         total++;
         if (got_q[i] !== model_out('{w[i], a[i], 1'b0}))
            begin bad++; $display("FAIL b2b_%0d: got %h want %h", i, got_q[i], model_out('{w[i], a[i], 1'b0})); end
      end
   endtask

   task automatic test_alternating();
      clear_q();
      in_mode = 1'b0;
      for (int c = 0; c < 200 && acc_q.size() < 24; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_data   = 16'($urandom);
         in_amt    = 4'($urandom);
         out_ready = c[0];
         tick();
      end
      drain();
      total++; if (got_q.size() != acc_q.size() || acc_q.size() < 24)
         begin bad++; $display("FAIL alt_count: got %0d out for %0d in, want 24 each", got_q.size(), acc_q.size()); end
      for (int i = 0; i < got_q.size() && i < acc_q.size(); i++) begin
         total++;
         if (got_q[i] !== model_out(acc_q[i]))
            begin bad++; $display("FAIL alt_%0d: got %h want %h", i, got_q[i], model_out(acc_q[i])); end
      end
   endtask

`ifdef ROTL_SHIFT_MODE_EN
   task automatic test_shift_mode();
      logic [15:0] e_tab [4];
      e_tab = '{16'h0002, 16'hF000, 16'h0003, 16'hFFFF};
      clear_q();
      out_ready = 1'b1;
      send(16'h8001, 4'd1,  1'b1);
      send(16'hFFFF, 4'd12, 1'b1);
      send(16'h8001, 4'd1,  1'b0);
      send(16'hFFFF, 4'd12, 1'b0);
      for (int k = 0; k < 30; k++) begin
         in_valid = 1'b1; in_data = 16'($urandom); in_amt = 4'($urandom); in_mode = 1'($urandom);
         tick();
      end
      drain();
      total++; if (got_q.size() != acc_q.size()) begin bad++; $display("FAIL shift_count: got %0d want %0d", got_q.size(), acc_q.size()); end
      for (int i = 0; i < 4 && i < got_q.size(); i++) begin
         total++;
         if (got_q[i] !== e_tab[i]) begin bad++; $display("FAIL shift_%0d: got %h want %h", i, got_q[i], e_tab[i]); end
      end
      for (int i = 4; i < got_q.size() && i < acc_q.size(); i++) begin
         total++;
         if (got_q[i] !== model_out(acc_q[i]))
            begin bad++; $display("FAIL shift_rand_%0d: got %h want %h", i, got_q[i], model_out(acc_q[i])); end
      end
      in_mode = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_latency();
      test_boundary();
      test_inverse();
      test_back_to_back();
      test_alternating();
`ifdef ROTL_SHIFT_MODE_EN
      test_shift_mode();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/barrel_rotl_pipe.md
# barrel_rotl_pipe

Pipelined 16-bit left rotator with valid/ready handshakes on both sides. It is the inverse of the datapath's 16-bit right-rotate barrel shifter, which computes `S[i] = A[(i+s) mod 16]`. Feeding that shifter's output and the same 4-bit amount into this block restores the original word. It sits on the write-back side of the shifter unit and provides an un-rotate path that is pipelined, so it can be stalled by downstream logic.

## Interface
- No parameters. Width is fixed at 16 bits and the amount at 4 bits.
- `clk  in  1` — single clock; all state updates on the rising edge.
- `rst  in  1` — synchronous reset, active-high.
- `in_valid  in  1` — input word and amount are valid.
- `in_ready  out  1` — block can accept this cycle.
- `in_data  in  16` — word to rotate.
- `in_amt  in  4` — rotate-left amount, 0..15 (equivalently `s3..s0` of the right rotator).
- `in_mode  in  1` — present only with `ROTL_SHIFT_MODE_EN`. 0 = rotate, 1 = logical shift-left with zero fill.
- `out_valid  out  1` — result valid.
- `out_ready  in  1` — downstream accepts this cycle.
- `out_data  out  16` — `Y[i] = D[(i - amt) mod 16]`.

## Operation
- Two register stages; the order is fine first, then coarse.
- **Stage 1 (fine):** rotate left by `amt[1:0]` (0..3 bits). Capture the partial word, `amt[3:2]`, mode, and `s1_valid`.
- **Stage 2 (coarse):** rotate left by `4*amt[3:2]` (0, 4, 8 or 12 bits). Capture into `out_data` and `out_valid`.
- **Total rotation:** `(amt[1:0] + 4*amt[3:2]) mod 16 = amt`. Arithmetic is modulo 16 and no carry leaves the 4-bit amount.
- **Stage 2 loads** when `s1_valid && (!out_valid || out_ready)`.
- **Output clear:** `out_valid` clears when `out_valid && out_ready` and stage 2 is not loading in the same cycle.
- **Stage 1 loads** when `in_valid && in_ready`.
- **`in_ready`:** `!rst && (!s1_valid || !out_valid || out_ready)`. This is a combinational back-pressure chain; there is no skid buffer.
- **Simultaneous pop and push:** if stage 2 pops and stage 1 advances and accepts a new input in the same cycle, throughput stays at 1 word/cycle.
- **Stall:** while `out_valid && !out_ready`, `out_data` and `out_valid` hold stable. Stage 1 holds too if it is full.
- **amt = 0:** passes the data through unchanged.
- **amt = 15:** equivalent to rotate-right by 1.
- **Handshake rule:** `in_data`, `in_amt` and `in_mode` are sampled only on an accepted handshake (`in_valid && in_ready`).

## Timing
- **Reset values:** `out_valid=0`, `out_data=16'h0000`, `s1_valid=0`, stage-1 data 0. `in_ready=0` while `rst` is high and 1 on the first cycle after `rst` falls.
- **Reset mid-operation:** reset discards in-flight words; nothing is emitted for them.
- **Latency:** accept at edge N gives `out_valid=1` after edge N+1, so the result is visible in the cycle following the second edge. This latency is 2 cycles.
- **Throughput:** 1 word/cycle with `out_ready` held high.
- **Capacity:** at most 2 words in flight.
- **Stall behaviour:** with `out_ready` low, `in_ready` falls in the cycle after both stages are full. No word is dropped or duplicated.
- **No combinational path** from `in_data` to `out_data`. The only combinational path is from `out_ready` to `in_ready`.

## Configuration
- **`ROTL_SHIFT_MODE_EN` defined:** adds the `in_mode` port, which is carried alongside the amount through both stages.
  - With mode=1, each stage zero-fills the bits it vacates, giving a logical shift-left by `amt`.
  - With mode=0, the block rotates.
- **`ROTL_SHIFT_MODE_EN` undefined:** the `in_mode` port is absent and the block always rotates. Datapath area drops to pure rotate muxes.

## Test plan
- **Reset:** assert `rst` 2 cycles during traffic → `out_valid=0`, `out_data=16'h0000`, `in_ready=0` during reset; `in_ready=1` on the first cycle after release.
- **Basic rotate:** `in_data=16'h0001`, `amt=5`, `out_ready=1` → `out_data=16'h0020` with `out_valid` exactly 2 cycles after accept. Then `16'h8001`, `amt=1` → `16'h0003`.
- **Inverse property:** for all 16 amounts and 1000 random words, rotate right in the model, then feed the result to this block → output equals the original word. Include `16'h4123`, `amt=4` → `16'h1234`.
- **Back-pressure:** stream 8 words back-to-back and hold `out_ready=0` for 5 cycles mid-stream →
  - `in_ready` falls after 2 words are buffered;
  - `out_data` is stable during the stall;
  - all 8 results come out in order with no loss or duplication.
- **Boundaries:** `amt=0` with `16'hA5A5` → `16'hA5A5`. `amt=15` with `16'h0001` → `16'h8000`. Alternating `out_ready` sustains correct ordering.
- **Shift mode (macro defined):** `mode=1`, `16'h8001`, `amt=1` → `16'h0002`; `16'hFFFF`, `amt=12` → `16'hF000`. With mode=0 the same inputs rotate.
